// File: rtl/pack4b_16b.sv
// pack4b_16b: assembles four valid nibbles into one 16-bit word.
// First nibble lands in [3:0]. flush emits a partial word, zero-padded.
// Optional: define PACK_PARITY_EN to add out_par, the XOR of out_w.
module pack4b_16b (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_b,
  input  logic        in_valid,
  input  logic        flush,
  output logic [15:0] out_w,
  output logic        out_valid,
`ifdef PACK_PARITY_EN
  output logic        out_par,
`endif
  output logic [2:0]  out_nib
);

  logic [1:0]  idx;
  logic [11:0] buffer;
  logic [15:0] word;
  logic [2:0]  nib;
  logic        emit;

  // Candidate word: held nibbles plus the incoming one at position idx.
  // Positions at and above idx are always zero in buffer, so the padding
  // of partial words comes for free.
  always_comb begin
    word = {4'h0, buffer};
    if (in_valid) word[{idx, 2'b00} +: 4] = in_b;
    nib  = {1'b0, idx} + {2'b00, in_valid};
    emit = (in_valid && idx == 2'd3) || (flush && (idx != 2'd0 || in_valid));
  end

  // Fill index, holding buffer and the registered output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= 2'd0;
      buffer    <= 12'h000;
      out_w     <= 16'h0000;
      out_valid <= 1'b0;
      out_nib   <= 3'd0;
`ifdef PACK_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (emit) begin
      out_w     <= word;
      out_nib   <= nib;
      out_valid <= 1'b1;
`ifdef PACK_PARITY_EN
      out_par   <= ^word;
`endif
      idx       <= 2'd0;
      buffer    <= 12'h000;
    end else begin
      out_valid <= 1'b0;
      // Without emit, in_valid implies idx<3, so the nibble fits in buffer.
      if (in_valid) begin
        buffer <= word[11:0];
        idx    <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pack4b_16b.sv
// Directed self-checking bench for pack4b_16b.
module tb_pack4b_16b;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  in_b = 4'h0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] out_w;
  logic        out_valid;
  logic [2:0]  out_nib;
`ifdef PACK_PARITY_EN
  logic        out_par;
`endif
  int checks = 0;
  int errors = 0;

  pack4b_16b dut (
    .clk(clk), .reset(reset), .in_b(in_b), .in_valid(in_valid), .flush(flush),
    .out_w(out_w), .out_valid(out_valid),
`ifdef PACK_PARITY_EN
    .out_par(out_par),
`endif
    .out_nib(out_nib)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] b, input logic f);
    in_valid = v; in_b = b; flush = f;
    tick();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_b = 4'hF;
    tick(); tick();
    checks++;
    if (out_w !== 16'h0000 || out_valid !== 1'b0 || out_nib !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: w=%h v=%b n=%0d, want 0000 0 0", out_w, out_valid, out_nib);
    end
`ifdef PACK_PARITY_EN
    checks++;
    if (out_par !== 1'b0) begin errors++; $display("FAIL reset_par: %b want 0", out_par); end
`endif
    in_valid = 1'b0;
    reset = 1'b1;
    drive(1'b1, 4'h1, 1'b0);
    drive(1'b0, 4'h0, 1'b1);
    checks++;
    if (out_w !== 16'h0001 || out_valid !== 1'b1 || out_nib !== 3'd1) begin
      errors++;
      $display("FAIL reset_release_first: w=%h v=%b n=%0d, want 0001 1 1", out_w, out_valid, out_nib);
    end
    tick();
  endtask

  task automatic test_full_word();
    logic [15:0] exp;
    exp = 16'h4321;
    drive(1'b1, 4'h1, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    drive(1'b1, 4'h3, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early: v=%b want 0", out_valid); end
    drive(1'b1, 4'h4, 1'b0);
    checks++;
    if (out_w !== exp || out_valid !== 1'b1 || out_nib !== 3'd4) begin
      errors++;
      $display("FAIL full_word: w=%h v=%b n=%0d, want 4321 1 4", out_w, out_valid, out_nib);
    end
`ifdef PACK_PARITY_EN
    checks++;
    if (out_par !== ^exp) begin errors++; $display("FAIL full_par: %b want %b", out_par, ^exp); end
`endif
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_w !== exp || out_nib !== 3'd4) begin
      errors++;
      $display("FAIL full_hold: w=%h v=%b n=%0d, want 4321 0 4", out_w, out_valid, out_nib);
    end
  endtask

  task automatic test_gapped();
    drive(1'b1, 4'hA, 1'b0); drive(1'b0, 4'h5, 1'b0);
    drive(1'b1, 4'hB, 1'b0); drive(1'b0, 4'h6, 1'b0); drive(1'b0, 4'h7, 1'b0);
    drive(1'b1, 4'hC, 1'b0); drive(1'b0, 4'h8, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL gapped_early: v=%b want 0", out_valid); end
    drive(1'b1, 4'hD, 1'b0);
    checks++;
    if (out_w !== 16'hDCBA || out_valid !== 1'b1 || out_nib !== 3'd4) begin
      errors++;
      $display("FAIL gapped_word: w=%h v=%b n=%0d, want dcba 1 4", out_w, out_valid, out_nib);
    end
    tick();
  endtask

  task automatic test_partial_flush();
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h6, 1'b0);
    drive(1'b0, 4'h0, 1'b1);
    checks++;
    if (out_w !== 16'h0065 || out_valid !== 1'b1 || out_nib !== 3'd2) begin
      errors++;
      $display("FAIL flush_two: w=%h v=%b n=%0d, want 0065 1 2", out_w, out_valid, out_nib);
    end
    drive(1'b1, 4'h7, 1'b1);
    checks++;
    if (out_w !== 16'h0007 || out_valid !== 1'b1 || out_nib !== 3'd1) begin
      errors++;
      $display("FAIL flush_one: w=%h v=%b n=%0d, want 0007 1 1", out_w, out_valid, out_nib);
    end
    drive(1'b0, 4'h9, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_w !== 16'h0007) begin
      errors++;
      $display("FAIL flush_empty: w=%h v=%b, want 0007 0", out_w, out_valid);
    end
    drive(1'b1, 4'h1, 1'b0); drive(1'b1, 4'h2, 1'b0); drive(1'b1, 4'h3, 1'b0);
    drive(1'b0, 4'hE, 1'b1);
    checks++;
    if (out_w !== 16'h0321 || out_valid !== 1'b1 || out_nib !== 3'd3) begin
      errors++;
      $display("FAIL flush_three: w=%h v=%b n=%0d, want 0321 1 3", out_w, out_valid, out_nib);
    end
    tick();
  endtask

  task automatic test_flush_complete();
    drive(1'b1, 4'h1, 1'b0); drive(1'b1, 4'h2, 1'b0); drive(1'b1, 4'h3, 1'b0);
    drive(1'b1, 4'hF, 1'b1);
    checks++;
    if (out_w !== 16'hF321 || out_valid !== 1'b1 || out_nib !== 3'd4) begin
      errors++;
      $display("FAIL flush_complete: w=%h v=%b n=%0d, want f321 1 4", out_w, out_valid, out_nib);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_complete_extra: v=%b want 0", out_valid); end
    // next word must start fresh at nibble 0
    drive(1'b1, 4'h9, 1'b1);
    checks++;
    if (out_w !== 16'h0009 || out_nib !== 3'd1) begin
      errors++;
      $display("FAIL flush_complete_after: w=%h n=%0d, want 0009 1", out_w, out_nib);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'h8, 1'b0);
    drive(1'b1, 4'h9, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_w !== 16'h0000 || out_valid !== 1'b0 || out_nib !== 3'd0) begin
      errors++;
      $display("FAIL reset_async: w=%h v=%b n=%0d, want 0000 0 0", out_w, out_valid, out_nib);
    end
    tick();
    reset = 1'b1;
    drive(1'b1, 4'h1, 1'b0); drive(1'b1, 4'h2, 1'b0); drive(1'b1, 4'h3, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_early: v=%b want 0", out_valid); end
    drive(1'b1, 4'h4, 1'b0);
    checks++;
    if (out_w !== 16'h4321 || out_valid !== 1'b1 || out_nib !== 3'd4) begin
      errors++;
      $display("FAIL reset_mid_word: w=%h v=%b n=%0d, want 4321 1 4", out_w, out_valid, out_nib);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_gapped();
    test_partial_flush();
    test_flush_complete();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
